// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding,
// control-bit positions and default payload/control widths per stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Bit positions inside the control vector.
  localparam int CTRL_WREG  = 0;
  localparam int CTRL_M2REG = 1;
  localparam int CTRL_WMEM  = 2;

  // ID->EX: {a[31:0], b[31:0], imm[31:0], rd[4:0]}
  localparam int IDEX_DATA_W = 101;
  localparam int IDEX_CTRL_W = 3;
  // EX->ME: {ans[31:0], b[31:0], rw[4:0]}
  localparam int EXME_DATA_W = 69;
  localparam int EXME_CTRL_W = 3;
  // ME->WB: {mo[31:0], ans[31:0], rw[4:0]}
  localparam int MEWB_DATA_W = 69;
  localparam int MEWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the stage: a valid bit, a payload and control bits.
// clear wins over load and zeroes valid and ctrl, leaving the payload as is.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXME_DATA_W,
  parameter int CTRL_W = EXME_CTRL_W
) (
  input  logic              clock,
  input  logic              reset_0,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      valid  <= 1'b0;
      q_data <= '0;
      q_ctrl <= '0;
    end else if (clear) begin
      // ctrl goes to zero with valid so a bubble never carries write enables
      valid  <= 1'b0;
      q_ctrl <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer and flush.
// Define PIPE_REG_STAT_EN to add saturating stall/flush statistics counters.
//
// Handshake: an entry moves when valid and ready are both high at a rising
// clock edge; valid never depends on ready, and in_ready is taken only from
// the skid slot's valid register, so out_ready has no combinational path to it.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXME_DATA_W,
  parameter int CTRL_W = EXME_CTRL_W
`ifdef PIPE_REG_STAT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clock,
  input  logic              reset_0,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_REG_STAT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output pipe_state_e       state
);

  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic              main_from_skid;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;

  logic              skid_valid;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              in_fire;
  logic              out_fire;
  pipe_state_e       st;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign state     = st;

  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (st)
        ST_EMPTY: main_load = in_fire;
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            skid_load = 1'b1;
          end else if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            main_clear = 1'b1;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Main refills from skid when draining TWO, otherwise straight from upstream.
  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      st <= ST_EMPTY;
    end else if (flush) begin
      st <= ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY: if (in_fire) st <= ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire) st <= ST_TWO;
          else if (!in_fire && out_fire) st <= ST_EMPTY;
        end
        ST_TWO:   if (out_fire) st <= ST_ONE;
        default:  st <= ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clock  (clock),
    .reset_0(reset_0),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid),
    .q_data (out_data),
    .q_ctrl (out_ctrl)
  );

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .clock  (clock),
    .reset_0(reset_0),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .valid  (skid_valid),
    .q_data (skid_data),
    .q_ctrl (skid_ctrl)
  );

`ifdef PIPE_REG_STAT_EN
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      // Only flushes that actually discard something are counted.
      if (flush && (main_valid || skid_valid) && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed plus randomized bench for pipe_reg_skid; the expected queue models
// the stage contents and is checked against the outputs every cycle.
module tb_pipe_reg_skid;
  import pipe_pkg::*;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 3;
  localparam int W      = DATA_W + CTRL_W;
`ifdef PIPE_REG_STAT_EN
  localparam int CNT_W  = 2;
`endif

  logic              clock;
  logic              reset_0;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  pipe_state_e       state;
`ifdef PIPE_REG_STAT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  m_stall;
  logic [CNT_W-1:0]  m_flush;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  pipe_reg_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PIPE_REG_STAT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clock    (clock),
    .reset_0  (reset_0),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
`ifdef PIPE_REG_STAT_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .state    (state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare outputs against the modelled contents
  task automatic check_outputs();
    pipe_state_e exp_st;
    exp_st = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_ONE : ST_TWO;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("state", state, exp_st);
    if (exp_q.size() > 0) chk("payload", {out_data, out_ctrl}, exp_q[0]);
    else chk("bubble_ctrl", out_ctrl, '0);
`ifdef PIPE_REG_STAT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  // driver: one clock cycle, inputs applied after the falling edge
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic rdy, input logic fl);
    logic m_in_ready;
    logic m_out_valid;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
    #1;
    check_outputs();
    m_in_ready  = exp_q.size() < 2;
    m_out_valid = exp_q.size() > 0;
`ifdef PIPE_REG_STAT_EN
    if (m_out_valid && !rdy && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
    if (fl && m_out_valid && m_flush != {CNT_W{1'b1}}) m_flush = m_flush + 1'b1;
`endif
    if (m_out_valid && rdy) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (v && m_in_ready) exp_q.push_back({d, c});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_reset();
    exp_q.delete();
`ifdef PIPE_REG_STAT_EN
    m_stall = '0;
    m_flush = '0;
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    n_cmp     = 0;
    n_err     = 0;
    reset_0   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_ctrl", out_ctrl, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset_0 = 1'b1;
    @(negedge clock);

    // stream 1,2,3 at full rate
    cycle(1'b1, 69'h1, 3'b001, 1'b1, 1'b0);
    cycle(1'b1, 69'h2, 3'b011, 1'b1, 1'b0);
    cycle(1'b1, 69'h3, 3'b101, 1'b1, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

    // backpressure: 0x22 lands in skid, 0x44 is refused
    cycle(1'b1, 69'h11, 3'b001, 1'b0, 1'b0);
    cycle(1'b1, 69'h22, 3'b010, 1'b0, 1'b0);
    cycle(1'b1, 69'h44, 3'b100, 1'b0, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b0, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

    // flush in TWO with a concurrent offer of 0x33
    cycle(1'b1, 69'hA1, 3'b111, 1'b0, 1'b0);
    cycle(1'b1, 69'hA2, 3'b111, 1'b0, 1'b0);
    cycle(1'b1, 69'h33, 3'b111, 1'b0, 1'b1);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

    // bubble ctrl, then a fresh entry passes untouched
    cycle(1'b1, 69'h5, 3'b111, 1'b0, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b0, 1'b1);
    cycle(1'b0, 69'h0, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 69'h6, 3'b010, 1'b1, 1'b0);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

    // flush while the consumer takes the main entry, with in_fire from ONE
    cycle(1'b1, 69'h7, 3'b001, 1'b0, 1'b0);
    cycle(1'b1, 69'h8, 3'b010, 1'b1, 1'b1);
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rd = {$urandom(), $urandom(), 5'($urandom_range(0, 31))};
      cycle(1'($urandom_range(0, 1)), rd, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // asynchronous reset in the middle of a cycle while in TWO
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b1);
    cycle(1'b1, 69'hB1, 3'b011, 1'b0, 1'b0);
    cycle(1'b1, 69'hB2, 3'b110, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check_outputs();
    #1;
    reset_0 = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, '0);
    chk("arst_out_ctrl", out_ctrl, '0);
    chk("arst_in_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clock);
    reset_0 = 1'b1;
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

`ifdef PIPE_REG_STAT_EN
    // stall counter saturation and a single counted flush
    cycle(1'b1, 69'hC1, 3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 69'h0, 3'b000, 1'b0, 1'b0);
    chk("stall_sat", stall_cnt, 2'd3);
    cycle(1'b0, 69'h0, 3'b000, 1'b0, 1'b1);
    cycle(1'b0, 69'h0, 3'b000, 1'b0, 1'b1);
    chk("flush_one", flush_cnt, 2'd1);
`endif
    cycle(1'b0, 69'h0, 3'b000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
